cb_rr: RTL and testbench

- Parametrised, registered successor to the 4-port combinational crossbar.
- Switches wormhole packets from NPORT inputs to NPORT outputs, with a per-output round-robin arbiter that locks from head to tail.
- Drives a per-input accept handshake and honours per-output backpressure.
- Sits between the input buffers and the output links of the switch.

---
 rtl/cb_pkg.sv | 17 +
 rtl/cb_rr_arb.sv | 38 +++
 rtl/cb_rr.sv | 77 +++++++
 tb/tb_cb_rr.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cb_pkg.sv
// cb_pkg: flit encoding, field extraction helpers and default sizing for the cb_rr crossbar
package cb_pkg;
    localparam int CB_NPORT = 4;
    localparam int CB_DW = 8;
    localparam int MAX_PKTW = 130;
    localparam logic [1:0] FT_IDLE = 2'b00;
    localparam logic [1:0] FT_BODY = 2'b01;
    localparam logic [1:0] FT_HEAD = 2'b10;
    localparam logic [1:0] FT_TAIL = 2'b11;
    function automatic logic [1:0] flit_type(input logic [MAX_PKTW-1:0] f, input int pktw);
        return 2'(f >> (pktw - 2));
    endfunction
    // Destination sits in the payload LSBs; NPORT is a power of two so a mask suffices
    function automatic logic [3:0] flit_dest(input logic [MAX_PKTW-1:0] f, input int nport);
        return 4'(f & MAX_PKTW'(nport - 1));
    endfunction
endpackage

// File: rtl/cb_rr_arb.sv
// cb_rr_arb: per-output round-robin arbiter that locks a grant from head until tail release
module cb_rr_arb #(
    parameter int NPORT = 4,
    localparam int PW = $clog2(NPORT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] req,
    input  logic             rel,
    output logic [NPORT-1:0] gnt
);
    logic [PW-1:0] ptr, widx, idx;
    logic [NPORT-1:0] win;
    // Scan downward so the nearest requester after ptr is the last one written
    always_comb begin
        win = '0;
        widx = ptr;
        idx = ptr;
        for (int k = NPORT; k >= 1; k--) begin
            idx = ptr + PW'(k);
            if (req[idx]) begin
                win = NPORT'(1) << idx;
                widx = idx;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt <= '0;
            ptr <= '1;
        end else if (|gnt) begin
            if (rel) gnt <= '0;
        end else if (|req) begin
            gnt <= win;
            ptr <= widx;
        end
    end
endmodule

// File: rtl/cb_rr.sv
// cb_rr: registered NPORT x NPORT wormhole crossbar with per-output round-robin head-to-tail locking
module cb_rr
    import cb_pkg::*;
#(
    parameter int NPORT = CB_NPORT,
    parameter int DW = CB_DW,
    localparam int PKTW = DW + 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT*PKTW-1:0]  in_flit,
    output logic [NPORT-1:0]       in_ack,
    input  logic [NPORT-1:0]       out_ready,
    output logic [NPORT*PKTW-1:0]  out_flit,
    output logic [NPORT*NPORT-1:0] gnt,
    output logic                   err
);
    logic [NPORT-1:0][PKTW-1:0] fl, ofl;
    logic [NPORT-1:0][1:0] ft;
    logic [NPORT-1:0][3:0] dst;
    logic [NPORT-1:0][NPORT-1:0] g;
    logic [NPORT-1:0] busy, stray, bad_head;
    assign fl = in_flit;
    assign out_flit = ofl;
    assign gnt = g;
    always_comb begin
        busy = '0;
        ft = '0;
        dst = '0;
        for (int o = 0; o < NPORT; o++) busy |= g[o];
        for (int n = 0; n < NPORT; n++) begin
            ft[n] = flit_type(MAX_PKTW'(fl[n]), PKTW);
            dst[n] = flit_dest(MAX_PKTW'(fl[n]), NPORT);
        end
    end
    // Body/tail at an ungranted input is swallowed so the input cannot stall forever
    always_comb begin
        stray = '0;
        bad_head = '0;
        for (int n = 0; n < NPORT; n++) stray[n] = (ft[n] == FT_BODY || ft[n] == FT_TAIL) && !busy[n];
        in_ack = stray;
        for (int o = 0; o < NPORT; o++) in_ack |= g[o] & {NPORT{out_ready[o]}};
        for (int n = 0; n < NPORT; n++) bad_head[n] = ft[n] == FT_HEAD && busy[n] && in_ack[n];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else if (|{stray, bad_head}) err <= 1'b1;
    end
    for (genvar o = 0; o < NPORT; o++) begin : g_out
        logic [NPORT-1:0] req, gq;
        logic [PKTW-1:0] mux, q;
        logic rel;
        always_comb begin
            req = '0;
            mux = '0;
            for (int n = 0; n < NPORT; n++) begin
                req[n] = ft[n] == FT_HEAD && dst[n] == 4'(o) && !busy[n];
                mux |= gq[n] ? fl[n] : '0;
            end
        end
        assign rel = out_ready[o] && flit_type(MAX_PKTW'(mux), PKTW) == FT_TAIL;
        cb_rr_arb #(.NPORT(NPORT)) u_arb (
            .clk(clk),
            .rst(rst),
            .req(req),
            .rel(rel),
            .gnt(gq)
        );
        // An ungranted output loads zero (idle) whenever downstream is ready
        always_ff @(posedge clk or posedge rst) begin
            if (rst) q <= '0;
            else if (out_ready[o]) q <= mux;
        end
        assign ofl[o] = q;
        assign g[o] = gq;
    end
endmodule

// File: tb/tb_cb_rr.sv
// tb_cb_rr: directed plus randomized bench for cb_rr against a packet-level reference model
module tb_cb_rr;
    localparam int N = 4;
    localparam int W = 10;
    logic clk = 1'b0;
    logic rst;
    logic [N*W-1:0] in_flit, out_flit;
    logic [N-1:0] in_ack, out_ready;
    logic [N*N-1:0] gnt;
    logic err;
    int npass = 0, ntot = 0, nfail = 0;
    logic [W-1:0] src [N][$];
    logic [W-1:0] cur [N];
    int owner [N];
    int ptr [N];
    logic [W-1:0] mout [N];
    logic merr;

    always #5 clk = ~clk;

    cb_rr #(.NPORT(N), .DW(8)) dut (
        .clk(clk),
        .rst(rst),
        .in_flit(in_flit),
        .in_ack(in_ack),
        .out_ready(out_ready),
        .out_flit(out_flit),
        .gnt(gnt),
        .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [1:0] t, input logic [7:0] p);
        return {t, p};
    endfunction

    task automatic mreset();
        for (int o = 0; o < N; o++) begin
            owner[o] = -1;
            ptr[o] = N - 1;
            mout[o] = '0;
        end
        merr = 1'b0;
    endtask

    task automatic push_pkt(input int i, input int d, input int nb, input bit wild);
        src[i].push_back(mk(2'b10, {6'($urandom), 2'(d)}));
        repeat (nb) src[i].push_back(mk((wild && $urandom_range(0, 9) == 0) ? 2'b10 : 2'b01, 8'($urandom)));
        src[i].push_back(mk(2'b11, 8'($urandom)));
    endtask

    task automatic cycle();
        logic [N-1:0] a, bz;
        logic [N*N-1:0] eg;
        logic [N*W-1:0] ef;
        logic [1:0] t;
        bit found;
        int c;
        for (int i = 0; i < N; i++) begin
            cur[i] = src[i].size() != 0 ? src[i][0] : '0;
            in_flit[i*W +: W] = cur[i];
        end
        #1;
        bz = '0;
        for (int o = 0; o < N; o++) if (owner[o] >= 0) bz[owner[o]] = 1'b1;
        for (int i = 0; i < N; i++) a[i] = (cur[i][9:8] == 2'b01 || cur[i][9:8] == 2'b11) && !bz[i];
        for (int o = 0; o < N; o++) if (owner[o] >= 0 && out_ready[o]) a[owner[o]] = 1'b1;
        chk("in_ack", 64'(in_ack), 64'(a));
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            t = cur[i][9:8];
            if (a[i] && (t == 2'b01 || t == 2'b11) && !bz[i]) merr = 1'b1;
            if (a[i] && t == 2'b10 && bz[i]) merr = 1'b1;
        end
        for (int o = 0; o < N; o++) begin
            if (owner[o] >= 0) begin
                if (out_ready[o]) begin
                    mout[o] = cur[owner[o]];
                    if (cur[owner[o]][9:8] == 2'b11) owner[o] = -1;
                end
            end else begin
                if (out_ready[o]) mout[o] = '0;
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    c = (ptr[o] + k) % N;
                    if (!found && cur[c][9:8] == 2'b10 && int'(cur[c][1:0]) == o && !bz[c]) begin
                        owner[o] = c;
                        ptr[o] = c;
                        found = 1'b1;
                    end
                end
            end
        end
        #1;
        eg = '0;
        ef = '0;
        for (int o = 0; o < N; o++) begin
            ef[o*W +: W] = mout[o];
            if (owner[o] >= 0) eg[o*N + owner[o]] = 1'b1;
        end
        chk("out_flit", 64'(out_flit), 64'(ef));
        chk("gnt", 64'(gnt), 64'(eg));
        chk("err", 64'(err), 64'(merr));
        for (int i = 0; i < N; i++)
            if (src[i].size() != 0 && (cur[i][9:8] == 2'b00 || a[i])) void'(src[i].pop_front());
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic areset();
        #2 rst = 1'b1;
        #1;
        mreset();
        for (int i = 0; i < N; i++) src[i].delete();
        chk("rst_flit", 64'(out_flit), 64'd0);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = '1;
        in_flit = '0;
        mreset();
        #12;
        chk("reset_flit", 64'(out_flit), 64'd0);
        chk("reset_gnt", 64'(gnt), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        rst = 1'b0;
        // single packet in0 -> out3
        src[0].push_back(10'h203);
        for (int b = 0; b < 4; b++) src[0].push_back(mk(2'b01, 8'(b)));
        src[0].push_back(10'h300);
        cycle();
        chk("t1_gnt3", 64'(gnt[15:12]), 64'h1);
        cycle();
        chk("t1_head", 64'(out_flit[39:30]), 64'h203);
        run(8);
        // contention on out1
        push_pkt(0, 1, 2, 1'b0);
        push_pkt(2, 1, 2, 1'b0);
        cycle();
        chk("t2_gnt1", 64'(gnt[7:4]), 64'h1);
        run(20);
        push_pkt(1, 1, 2, 1'b0);
        push_pkt(2, 1, 2, 1'b0);
        cycle();
        chk("t2_rr", 64'(gnt[7:4]), 64'h2);
        run(20);
        // parallel grants
        push_pkt(0, 2, 3, 1'b0);
        push_pkt(1, 3, 3, 1'b0);
        cycle();
        chk("t3_par", 64'(gnt), 64'h2100);
        run(10);
        // backpressure on out3
        push_pkt(0, 3, 6, 1'b0);
        run(4);
        out_ready = 4'b0111;
        run(3);
        out_ready = 4'b1111;
        run(10);
        // stray body
        src[3].push_back(10'h1AA);
        cycle();
        chk("t5_err", 64'(err), 64'd1);
        run(2);
        // asynchronous reset mid-packet
        push_pkt(0, 3, 4, 1'b0);
        run(4);
        areset();
        push_pkt(2, 3, 2, 1'b0);
        cycle();
        chk("t6_gnt3", 64'(gnt[15:12]), 64'h4);
        run(8);
        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (src[i].size() == 0) begin
                    int r;
                    r = $urandom_range(0, 15);
                    if (r < 5) push_pkt(i, $urandom_range(0, 3), $urandom_range(0, 4), 1'b1);
                    else if (r == 5) src[i].push_back(mk($urandom_range(0, 1) != 0 ? 2'b01 : 2'b11, 8'($urandom)));
                    else if (r == 6) src[i].push_back('0);
                end
            end
            for (int o = 0; o < N; o++) out_ready[o] = $urandom_range(0, 4) != 0;
            cycle();
            if (c == 1500) areset();
        end
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
